// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: requester count,
// index width, FSM state encodings and the round-robin search helper.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // First set bit of req searching upward from start, wrapping 3 -> 0.
    // Returns start when req is empty; callers only use it when req != 0.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   start
    );
        logic [IDX_W-1:0] idx;
        rr_pick = start;
        // Walk from the farthest candidate back to start so the closest one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = start + IDX_W'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/grant_decoder_2_4.sv
// 2-to-4 one-hot decoder with enable; all-zero output when disabled.
module grant_decoder_2_4
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0]   i_idx,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt
);

    // Decode the index to a single hot bit, gated by the enable.
    always_comb begin
        o_gnt = '0;
        if (i_en) o_gnt[i_idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter. A winner keeps the grant until it drops its
// request; the grant then moves to the next requester with no idle bubble.
// Optional feature macro: RR_ARB_TIMEOUT_EN -- adds an 8-bit hold counter
// that forces a hand-off after MAX_HOLD granted cycles when others wait.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    // MAX_HOLD must fit the 8-bit hold counter and leave room for one hold cycle.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter_4: MAX_HOLD out of range 2..255");
    end

    arb_state_t         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [NUM_REQ-1:0] w_self;
    logic [NUM_REQ-1:0] w_other_req;
    logic               w_others;
    logic               w_timeout;
    logic               w_new_grant;

    assign w_self      = NUM_REQ'(1) << r_idx;
    assign w_other_req = req & ~w_self;
    assign w_others    = |w_other_req;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    logic [7:0] r_hold, w_hold_nxt;

    // Force a hand-off only when the hold limit is reached and someone is waiting.
    assign w_timeout = (r_hold == HOLD_LIM) && w_others;

    // Hold counter: clear on each new grant, count while granted, saturate at the limit.
    always_comb begin
        w_hold_nxt = r_hold;
        if (w_new_grant)
            w_hold_nxt = '0;
        else if (r_state == ARB_GRANT && r_hold != HOLD_LIM)
            w_hold_nxt = r_hold + 8'd1;
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hold <= '0;
        else        r_hold <= w_hold_nxt;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state, winner selection and pointer update.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_new_grant = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (|req) begin
                    w_state_nxt = ARB_GRANT;
                    w_idx_nxt   = rr_pick(req, r_ptr);
                    w_new_grant = 1'b1;
                end
            end
            ARB_GRANT: begin
                // Other requesters' bits are ignored unless the grantee lets go
                // (or is timed out).
                if (!req[r_idx] || w_timeout) begin
                    if (w_others) begin
                        w_idx_nxt   = rr_pick(w_other_req, r_idx + 1'b1);
                        w_new_grant = 1'b1;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                    end
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
        if (w_new_grant) w_ptr_nxt = w_idx_nxt + 1'b1;
    end

    // State, grantee index and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign gnt_valid = (r_state == ARB_GRANT);
    assign gnt_idx   = r_idx;

    grant_decoder_2_4 u_dec (
        .i_idx (r_idx),
        .i_en  (gnt_valid),
        .o_gnt (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios plus randomized
// requests checked against a behavioural round-robin model.
module tb_rr_arbiter_4;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner (-1 when idle), pointer, hold count.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        tick();
        rst_n   = 1'b1;
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
    endtask

    function automatic int ref_pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++)
            if (r[(start + k) % 4]) return (start + k) % 4;
        return -1;
    endfunction

    // One clock edge of the arbitration rules applied to requests r.
    task automatic model_step(input logic [3:0] r);
        logic [3:0] others;
        bit         let_go;
        int         w;
        if (m_owner < 0) begin
            if (r != 4'b0000) begin
                w       = ref_pick(r, m_ptr);
                m_owner = w;
                m_ptr   = (w + 1) % 4;
                m_hold  = 0;
            end
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            let_go = !r[m_owner];
`ifdef RR_ARB_TIMEOUT_EN
            if (m_hold == MH - 1 && others != 4'b0000) let_go = 1'b1;
`endif
            if (let_go) begin
                if (others != 4'b0000) begin
                    w       = ref_pick(others, (m_owner + 1) % 4);
                    m_owner = w;
                    m_ptr   = (w + 1) % 4;
                    m_hold  = 0;
                end else begin
                    m_owner = -1;
                end
            end else if (m_hold < MH - 1) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'b00) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d gnt=%b valid=%b idx=%0d required gnt=0000 valid=0 idx=0",
                         c, gnt, gnt_valid, gnt_idx);
            end
            tick();
        end
    endtask

    task automatic test_single;
        do_reset();
        req = 4'b0100;
        tick();
        n_cmp++;
        if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || gnt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant gnt=%b idx=%0d valid=%b required 0100/2/1", gnt, gnt_idx, gnt_valid);
        end
        req = 4'b0000;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_release gnt=%b valid=%b required 0000/0", gnt, gnt_valid);
        end
    endtask

    task automatic test_fairness;
        logic [3:0] exp;
        do_reset();
        req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            exp = 4'b0001 << (g % 4);
            for (int c = 0; c < 3; c++) begin
                n_cmp++;
                if (gnt !== exp || gnt_idx !== 2'(g % 4) || $countones(gnt) > 1) begin
                    n_err++;
                    $display("FAIL fairness g=%0d c=%0d gnt=%b idx=%0d required gnt=%b idx=%0d",
                             g, c, gnt, gnt_idx, exp, g % 4);
                end
                if (c == 2) req = 4'b1111 & ~exp;
                tick();
                req = 4'b1111;
            end
        end
    endtask

    task automatic test_wrap_no_bubble;
        do_reset();
        req = 4'b1000;
        tick();
        req = 4'b1001;
        tick();
        n_cmp++;
        if (gnt !== 4'b1000) begin
            n_err++;
            $display("FAIL wrap_hold gnt=%b required 1000", gnt);
        end
        req = 4'b0001;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001 || gnt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_handoff gnt=%b valid=%b required 0001/1", gnt, gnt_valid);
        end
    endtask

    task automatic test_mid_reset;
        do_reset();
        req = 4'b0010;
        tick();
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL midrst_pre gnt=%b required 0010", gnt);
        end
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_async gnt=%b valid=%b required 0000/0", gnt, gnt_valid);
        end
        rst_n = 1'b1;
        req   = 4'b0011;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
            n_err++;
            $display("FAIL midrst_restart gnt=%b idx=%0d required 0001/0", gnt, gnt_idx);
        end
    endtask

    task automatic test_hold;
        logic [3:0] exp;
        do_reset();
        req = 4'b0011;
`ifdef RR_ARB_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp = (((k - 1) / MH) % 2 == 1) ? 4'b0010 : 4'b0001;
            n_cmp++;
            if (gnt !== exp) begin
                n_err++;
                $display("FAIL timeout_alt k=%0d gnt=%b required %b", k, gnt, exp);
            end
        end
        req = 4'b0001;
`endif
        exp = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_cmp++;
            if (gnt !== exp) begin
                n_err++;
                $display("FAIL hold_keep k=%0d gnt=%b required %b", k, gnt, exp);
            end
        end
    endtask

    task automatic test_random;
        logic [3:0] r;
        logic [3:0] exp;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = 4'($urandom);
            if (m_owner >= 0 && $urandom_range(3) != 0) r[m_owner] = 1'b1;
            req = r;
            model_step(r);
            tick();
            exp = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            n_cmp++;
            if (gnt !== exp || gnt_valid !== (m_owner >= 0) ||
                (m_owner >= 0 && gnt_idx !== 2'(m_owner))) begin
                n_err++;
                $display("FAIL random cyc=%0d req=%b gnt=%b valid=%b idx=%0d required gnt=%b owner=%0d",
                         c, r, gnt, gnt_valid, gnt_idx, exp, m_owner);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap_no_bubble();
        test_mid_reset();
        test_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
